// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC owner, icache read issue, IF/ID write control.
// Optional one-entry stall buffer enabled by defining FETCH_BUF_EN.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall_ID,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        halt,
    output logic [31:0] instruction,
    output logic [31:0] npc_IF,
    output logic        enable_IF_ID,
    output logic        flush_IF_ID
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] pc_plus4;
    logic        en_c, fl_c;

`ifdef FETCH_BUF_EN
    logic [31:0] ibuf_q, ibuf_d;
    logic [31:0] ibuf_pc_q, ibuf_pc_d;
    logic        ibuf_valid_q, ibuf_valid_d;
`endif

    assign pc_plus4 = pc_q + 32'd4;
    assign imemaddr = pc_q;

    // IF/ID controls stay quiet while reset is held, whatever the inputs do
    assign enable_IF_ID = en_c && nRST;
    assign flush_IF_ID  = fl_c && nRST;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        imemREN     = 1'b1;
        en_c        = 1'b0;
        fl_c        = 1'b0;
        instruction = imemload;
        npc_IF      = pc_plus4;
`ifdef FETCH_BUF_EN
        ibuf_d       = ibuf_q;
        ibuf_pc_d    = ibuf_pc_q;
        ibuf_valid_d = ibuf_valid_q;
`endif
        unique case (state_q)
            FETCH: begin
`ifdef FETCH_BUF_EN
                if (ibuf_valid_q) begin
                    imemREN     = 1'b0;
                    instruction = ibuf_q;
                    npc_IF      = ibuf_pc_q;
                end
`endif
                if (halt) begin
                    state_d = HALTED;
                    fl_c    = 1'b1;
`ifdef FETCH_BUF_EN
                    ibuf_valid_d = 1'b0;
`endif
                end else if (redirect) begin
                    fl_c = 1'b1;
`ifdef FETCH_BUF_EN
                    ibuf_valid_d = 1'b0;
`endif
                    if (ihit) begin
                        pc_d = redirect_addr;
                    end else begin
                        // miss in flight: let it land before moving PC
                        pend_d  = redirect_addr;
                        state_d = DRAIN;
                    end
`ifdef FETCH_BUF_EN
                end else if (ibuf_valid_q) begin
                    en_c = !stall_ID;
                    if (!stall_ID) ibuf_valid_d = 1'b0;
                end else if (ihit && stall_ID) begin
                    ibuf_d       = imemload;
                    ibuf_pc_d    = pc_plus4;
                    ibuf_valid_d = 1'b1;
                    pc_d         = pc_plus4;
`endif
                end else if (ihit && !stall_ID) begin
                    en_c = 1'b1;
                    pc_d = pc_plus4;
                end
            end
            DRAIN: begin
                if (halt) begin
                    state_d = HALTED;
                end else begin
                    if (redirect) pend_d = redirect_addr;
                    if (ihit) begin
                        pc_d    = redirect ? redirect_addr : pend_q;
                        state_d = FETCH;
                    end
                end
            end
            HALTED: begin
                imemREN = 1'b0;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FETCH;
            pc_q    <= PC_INIT;
            pend_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

`ifdef FETCH_BUF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ibuf_q       <= 32'h0;
            ibuf_pc_q    <= 32'h0;
            ibuf_valid_q <= 1'b0;
        end else begin
            ibuf_q       <= ibuf_d;
            ibuf_pc_q    <= ibuf_pc_d;
            ibuf_valid_q <= ibuf_valid_d;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage (default build, no stall buffer).
// Directed cases from the fetch rules, then randomized traffic vs a reference model.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        stall_ID;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        halt;
    logic [31:0] instruction;
    logic [31:0] npc_IF;
    logic        enable_IF_ID;
    logic        flush_IF_ID;

    int checks = 0;
    int errors = 0;

    // reference model: mode 0 = fetching, 1 = waiting out a miss, 2 = halted
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    int          m_mode;

    fetch_stage #(.PC_INIT(32'h0)) dut (
        .CLK(CLK),
        .nRST(nRST),
        .ihit(ihit),
        .imemload(imemload),
        .imemREN(imemREN),
        .imemaddr(imemaddr),
        .stall_ID(stall_ID),
        .redirect(redirect),
        .redirect_addr(redirect_addr),
        .halt(halt),
        .instruction(instruction),
        .npc_IF(npc_IF),
        .enable_IF_ID(enable_IF_ID),
        .flush_IF_ID(flush_IF_ID)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // called at a falling edge; leaves at the next falling edge
    task automatic step(input logic ih, input logic stl, input logic rd,
                        input logic [31:0] ra, input logic hl);
        logic en_e, fl_e, ren_e;
        ihit          = ih;
        stall_ID      = stl;
        redirect      = rd;
        redirect_addr = ra;
        halt          = hl;
        imemload      = m_pc ^ 32'hC0DE_0000 ^ {31'h0, ih};
        #1;
        ren_e = (m_mode != 2);
        fl_e  = (m_mode == 0) && (hl || rd);
        en_e  = (m_mode == 0) && !hl && !rd && ih && !stl;
        check("imemaddr", imemaddr, m_pc);
        check("imemREN", {31'h0, imemREN}, {31'h0, ren_e});
        check("enable", {31'h0, enable_IF_ID}, {31'h0, en_e});
        check("flush", {31'h0, flush_IF_ID}, {31'h0, fl_e});
        if (en_e) begin
            check("npc_IF", npc_IF, m_pc + 32'd4);
            check("instr", instruction, imemload);
        end
        @(posedge CLK);
        if (m_mode == 0) begin
            if (hl) m_mode = 2;
            else if (rd && ih) m_pc = ra;
            else if (rd) begin
                m_pend = ra;
                m_mode = 1;
            end else if (ih && !stl) m_pc = m_pc + 32'd4;
        end else if (m_mode == 1) begin
            if (hl) m_mode = 2;
            else begin
                if (rd) m_pend = ra;
                if (ih) begin
                    m_pc   = m_pend;
                    m_mode = 0;
                end
            end
        end
        @(negedge CLK);
    endtask

    // async reset asserted between edges with junk on the inputs
    task automatic do_reset();
        nRST     = 1'b0;
        ihit     = 1'b1;
        redirect = 1'b1;
        halt     = 1'b0;
        stall_ID = 1'b0;
        redirect_addr = 32'hDEAD_BEE0;
        #1;
        m_pc   = 32'h0;
        m_pend = 32'h0;
        m_mode = 0;
        check("rst_addr", imemaddr, 32'h0);
        check("rst_ren", {31'h0, imemREN}, 32'h1);
        check("rst_en", {31'h0, enable_IF_ID}, 32'h0);
        check("rst_flush", {31'h0, flush_IF_ID}, 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        nRST = 1'b0;
        ihit = 1'b0;
        stall_ID = 1'b0;
        redirect = 1'b0;
        redirect_addr = 32'h0;
        halt = 1'b0;
        imemload = 32'h0;
        m_pc = 32'h0;
        m_pend = 32'h0;
        m_mode = 0;
        @(negedge CLK);
        do_reset();

        // straight-line fetch: 0,4,8,C
        for (int i = 0; i < 4; i++) begin
            check("seq_addr", imemaddr, 32'(4 * i));
            step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        end

        // restart, then stall three cycles at PC 0x8
        do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("stall_addr", imemaddr, 32'h8);
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // redirect on the hit path at PC 0x10
        check("pre_redir", imemaddr, 32'h10);
        step(1'b1, 1'b0, 1'b1, 32'h100, 1'b0);
        check("redir_hit", imemaddr, 32'h100);

        // redirect during a miss, four more miss cycles, then the hit
        step(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("drain_addr", imemaddr, 32'h100);
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check("drain_tgt", imemaddr, 32'h200);

        // second redirect overrides the first while draining
        step(1'b0, 1'b0, 1'b1, 32'h400, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h300, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check("drain_2nd", imemaddr, 32'h300);

        // PC+4 wraps past the top of the address space; low bits kept
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        check("wrap_npc", npc_IF, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check("wrap_addr", imemaddr, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0123, 1'b0);
        check("raw_target", imemaddr, 32'h0000_0123);

        // halt beats redirect, then stays halted
        step(1'b1, 1'b0, 1'b1, 32'h500, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("halt_ren", {31'h0, imemREN}, 32'h0);
            step(1'b1, 1'b0, 1'b1, 32'h600, 1'b0);
        end
        do_reset();
        check("post_halt", imemaddr, 32'h0);

        // reset asserted in the middle of a miss drain
        step(1'b0, 1'b0, 1'b1, 32'h700, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check("rst_drain", imemaddr, 32'h4);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (m_mode == 2 && $urandom_range(3) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(2) != 0,
                     $urandom_range(3) == 0,
                     $urandom_range(6) == 0,
                     $urandom,
                     $urandom_range(40) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
